// File: rtl/deserializer_4b.sv
// LSB-first serial-to-parallel receiver with a one-word holding register,
// ack-based handshake, sticky overrun flag and synchronous clear.
module deserializer_4b #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  input  logic                       ack,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;

  // New bits enter at the MSB so the first bit ends up in bit 0.
  assign sr_shifted = {bit_in, sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      data_out <= '0;
      bit_cnt  <= '0;
      overrun  <= 1'b0;
    end else if (clear) begin
      // Abort everything except the last delivered word.
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bit_valid) begin
            sr      <= sr_shifted;
            bit_cnt <= CNT_ONE;
            state   <= RECV;
          end
        end
        RECV: begin
          if (bit_valid) begin
            sr <= sr_shifted;
            if (bit_cnt == CNT_LAST) begin
              data_out <= sr_shifted;
              bit_cnt  <= '0;
              state    <= FULL;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end
        FULL: begin
          if (ack) begin
            // Accepting a bit in the ack cycle keeps back-to-back streams lossless.
            if (bit_valid) begin
              sr      <= sr_shifted;
              bit_cnt <= CNT_ONE;
              state   <= RECV;
            end else begin
              state <= IDLE;
            end
          end else if (bit_valid) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == RECV);
  assign data_valid = (state == FULL);

endmodule
